// File: rtl/branch_redirect_unit_if.sv
// Fetch-side redirect bundle: EX resolution inputs in, PC and flush controls out.
interface branch_redirect_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic             ex_valid;
  logic             ex_beq;
  logic             ex_bne;
  logic             ex_jump;
  logic [31:0]      ex_pc_plus1;
  logic [31:0]      ex_offset;
  logic [25:0]      ex_jindex;
  logic [31:0]      ex_rs_data;
  logic [31:0]      ex_rt_data;
  logic [31:0]      pc;
  logic [31:0]      pc_plus1;
  logic             redirect;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport slave (
    input  stall, ex_valid, ex_beq, ex_bne, ex_jump,
           ex_pc_plus1, ex_offset, ex_jindex, ex_rs_data, ex_rt_data,
    output pc, pc_plus1, redirect, flush_id_ex, flush_ex_mem,
           branch_count, taken_count
  );

  modport master (
    output stall, ex_valid, ex_beq, ex_bne, ex_jump,
           ex_pc_plus1, ex_offset, ex_jindex, ex_rs_data, ex_rt_data,
    input  pc, pc_plus1, redirect, flush_id_ex, flush_ex_mem,
           branch_count, taken_count
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Word-addressed PC owner: resolves beq/bne/j in EX, redirects fetch and
// kills the two wrong-path instructions during a one-cycle shadow.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = '0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_redirect_unit_if.slave bif
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        operands_eq;
  logic        resolve;
  logic        take;
  logic [31:0] target;

  assign operands_eq = (bif.ex_rs_data == bif.ex_rt_data);
  assign resolve     = bif.ex_valid && (state_q == RUN);

  // Jump wins over branches; beq wins over bne when both are set.
  always_comb begin
    take   = 1'b0;
    target = bif.ex_pc_plus1 + bif.ex_offset;
    if (bif.ex_jump) begin
      take   = resolve;
      target = {bif.ex_pc_plus1[31:26], bif.ex_jindex};
    end else if (bif.ex_beq) begin
      take = resolve && operands_eq;
    end else if (bif.ex_bne) begin
      take = resolve && !operands_eq;
    end
  end

  always_comb begin
    state_d      = RUN;
    pc_d         = pc_q + 32'd1;
    redirect_d   = 1'b0;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    unique case (state_q)
      RUN: begin
        if (take) begin
          pc_d        = target;
          state_d     = SHADOW;
          redirect_d  = 1'b1;
          taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end else if (bif.stall) begin
          pc_d = pc_q;
        end
        if (resolve && (bif.ex_beq || bif.ex_bne))
          branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      SHADOW: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Both flushes coincide with redirect: the shadow cycle kills br+1 and br+2.
  assign bif.pc           = pc_q;
  assign bif.pc_plus1     = pc_q + 32'd1;
  assign bif.redirect     = redirect_q;
  assign bif.flush_id_ex  = redirect_q;
  assign bif.flush_ex_mem = redirect_q;
  assign bif.branch_count = branch_cnt_q;
  assign bif.taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit (CNT_W=4 build).
module tb_branch_redirect_unit;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  branch_redirect_unit_if #(.CNT_W(CNT_W)) bif ();

  branch_redirect_unit #(
    .RESET_PC (32'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ex();
    bif.ex_valid    = 1'b0;
    bif.ex_beq      = 1'b0;
    bif.ex_bne      = 1'b0;
    bif.ex_jump     = 1'b0;
    bif.ex_pc_plus1 = '0;
    bif.ex_offset   = '0;
    bif.ex_jindex   = '0;
    bif.ex_rs_data  = '0;
    bif.ex_rt_data  = '0;
  endtask

  task automatic do_reset();
    bif.stall = 1'b0;
    clear_ex();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bif.stall = 1'b0;
    clear_ex();
    reset = 1'b1;
    tick();
    n_checks++;
    if (bif.pc !== 32'h0 || bif.redirect !== 1'b0 || bif.flush_id_ex !== 1'b0 ||
        bif.flush_ex_mem !== 1'b0 || bif.branch_count !== 4'h0 || bif.taken_count !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h redir=%b fie=%b fem=%b bc=%h tc=%h, want pc=0 flags 0 counts 0",
               bif.pc, bif.redirect, bif.flush_id_ex, bif.flush_ex_mem,
               bif.branch_count, bif.taken_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bif.pc !== 32'(i) || bif.pc_plus1 !== 32'(i + 1) || bif.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL free_run[%0d]: pc=%h pc_plus1=%h redir=%b, want pc=%h pc_plus1=%h redir=0",
                 i, bif.pc, bif.pc_plus1, bif.redirect, 32'(i), 32'(i + 1));
      end
      if (i != 3) tick();
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bif.pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h, want 00000000 before next edge", bif.pc);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_beq_taken();
    do_reset();
    bif.ex_valid    = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_pc_plus1 = 32'h10;
    bif.ex_offset   = 32'hFFFF_FFFC;
    bif.ex_rs_data  = 32'd5;
    bif.ex_rt_data  = 32'd5;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'h0C || bif.redirect !== 1'b1 || bif.flush_id_ex !== 1'b1 ||
        bif.flush_ex_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_target: pc=%h redir=%b fie=%b fem=%b, want pc=0000000c flags 1",
               bif.pc, bif.redirect, bif.flush_id_ex, bif.flush_ex_mem);
    end
    tick();
    n_checks++;
    if (bif.pc !== 32'h0D || bif.redirect !== 1'b0 || bif.flush_id_ex !== 1'b0 ||
        bif.flush_ex_mem !== 1'b0 || bif.branch_count !== 4'd1 || bif.taken_count !== 4'd1) begin
      n_fail++;
      $display("FAIL beq_after: pc=%h redir=%b fie=%b fem=%b bc=%0d tc=%0d, want pc=0000000d flags 0 bc=1 tc=1",
               bif.pc, bif.redirect, bif.flush_id_ex, bif.flush_ex_mem,
               bif.branch_count, bif.taken_count);
    end
  endtask

  task automatic test_bne_not_taken();
    do_reset();
    bif.ex_valid    = 1'b1;
    bif.ex_bne      = 1'b1;
    bif.ex_pc_plus1 = 32'h20;
    bif.ex_offset   = 32'd8;
    bif.ex_rs_data  = 32'd7;
    bif.ex_rt_data  = 32'd7;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'h1 || bif.redirect !== 1'b0 || bif.flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_nt: pc=%h redir=%b fie=%b, want pc=00000001 flags 0",
               bif.pc, bif.redirect, bif.flush_id_ex);
    end
    tick();
    n_checks++;
    if (bif.pc !== 32'h2 || bif.branch_count !== 4'd1 || bif.taken_count !== 4'd0) begin
      n_fail++;
      $display("FAIL bne_counts: pc=%h bc=%0d tc=%0d, want pc=00000002 bc=1 tc=0",
               bif.pc, bif.branch_count, bif.taken_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bif.ex_valid    = 1'b1;
    bif.ex_jump     = 1'b1;
    bif.ex_pc_plus1 = 32'hF000_0004;
    bif.ex_jindex   = 26'h000_0123;
    tick();
    n_checks++;
    if (bif.pc !== 32'hF000_0123 || bif.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_target: pc=%h redir=%b, want pc=f0000123 redir=1", bif.pc, bif.redirect);
    end
    // Taken beq presented in the shadow must be ignored.
    clear_ex();
    bif.ex_valid    = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_pc_plus1 = 32'h100;
    bif.ex_offset   = 32'h50;
    bif.ex_rs_data  = 32'd9;
    bif.ex_rt_data  = 32'd9;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'hF000_0124 || bif.redirect !== 1'b0 || bif.taken_count !== 4'd1 ||
        bif.branch_count !== 4'd0) begin
      n_fail++;
      $display("FAIL shadow_ignore: pc=%h redir=%b tc=%0d bc=%0d, want pc=f0000124 redir=0 tc=1 bc=0",
               bif.pc, bif.redirect, bif.taken_count, bif.branch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    bif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bif.pc !== 32'h7) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h, want 00000007", i, bif.pc);
      end
    end
    bif.stall = 1'b0;
    tick();
    n_checks++;
    if (bif.pc !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h, want 00000008", bif.pc);
    end
    bif.stall       = 1'b1;
    bif.ex_valid    = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_pc_plus1 = 32'h10;
    bif.ex_offset   = 32'h30;
    bif.ex_rs_data  = 32'd3;
    bif.ex_rt_data  = 32'd3;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'h40 || bif.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_take: pc=%h redir=%b, want pc=00000040 redir=1", bif.pc, bif.redirect);
    end
    tick();
    n_checks++;
    if (bif.pc !== 32'h41) begin
      n_fail++;
      $display("FAIL stall_shadow: pc=%h, want 00000041", bif.pc);
    end
    tick();
    n_checks++;
    if (bif.pc !== 32'h41) begin
      n_fail++;
      $display("FAIL stall_after_shadow: pc=%h, want 00000041", bif.pc);
    end
    bif.stall = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    // Jump with beq also set: jump target wins, branch still counted.
    bif.ex_valid    = 1'b1;
    bif.ex_jump     = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_pc_plus1 = 32'hA000_0010;
    bif.ex_offset   = 32'h5;
    bif.ex_jindex   = 26'h3FF_FFFF;
    bif.ex_rs_data  = 32'd1;
    bif.ex_rt_data  = 32'd2;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'hA3FF_FFFF || bif.branch_count !== 4'd1 || bif.taken_count !== 4'd1) begin
      n_fail++;
      $display("FAIL jump_priority: pc=%h bc=%0d tc=%0d, want pc=a3ffffff bc=1 tc=1",
               bif.pc, bif.branch_count, bif.taken_count);
    end
    tick();
    // beq and bne together with equal operands behaves as beq (taken).
    bif.ex_valid    = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_bne      = 1'b1;
    bif.ex_pc_plus1 = 32'h200;
    bif.ex_offset   = 32'h10;
    bif.ex_rs_data  = 32'd4;
    bif.ex_rt_data  = 32'd4;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'h210 || bif.branch_count !== 4'd2 || bif.taken_count !== 4'd2) begin
      n_fail++;
      $display("FAIL beq_bne_priority: pc=%h bc=%0d tc=%0d, want pc=00000210 bc=2 tc=2",
               bif.pc, bif.branch_count, bif.taken_count);
    end
    tick();
  endtask

  task automatic test_offset_wrap();
    do_reset();
    bif.ex_valid    = 1'b1;
    bif.ex_beq      = 1'b1;
    bif.ex_pc_plus1 = 32'hFFFF_FFFF;
    bif.ex_offset   = 32'd2;
    bif.ex_rs_data  = 32'hDEAD_BEEF;
    bif.ex_rt_data  = 32'hDEAD_BEEF;
    tick();
    clear_ex();
    n_checks++;
    if (bif.pc !== 32'h1 || bif.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL offset_wrap: pc=%h redir=%b, want pc=00000001 redir=1", bif.pc, bif.redirect);
    end
    tick();
  endtask

  task automatic test_shadow_reset();
    do_reset();
    bif.ex_valid = 1'b1;
    bif.ex_jump  = 1'b1;
    bif.ex_jindex = 26'h55;
    tick();
    clear_ex();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bif.pc !== 32'h0 || bif.redirect !== 1'b0 || bif.flush_ex_mem !== 1'b0 ||
        bif.taken_count !== 4'd0) begin
      n_fail++;
      $display("FAIL shadow_reset: pc=%h redir=%b fem=%b tc=%0d, want all 0",
               bif.pc, bif.redirect, bif.flush_ex_mem, bif.taken_count);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (bif.pc !== 32'h1) begin
      n_fail++;
      $display("FAIL post_shadow_reset: pc=%h, want 00000001", bif.pc);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bif.ex_valid    = 1'b1;
      bif.ex_beq      = 1'b1;
      bif.ex_pc_plus1 = 32'h100;
      bif.ex_offset   = 32'(i);
      bif.ex_rs_data  = 32'd0;
      bif.ex_rt_data  = 32'd0;
      tick();
      clear_ex();
      tick();
      if (i == 14) begin
        n_checks++;
        if (bif.taken_count !== 4'hF || bif.branch_count !== 4'hF) begin
          n_fail++;
          $display("FAIL counter_full: tc=%h bc=%h, want f f", bif.taken_count, bif.branch_count);
        end
      end
    end
    n_checks++;
    if (bif.taken_count !== 4'h0 || bif.branch_count !== 4'h0) begin
      n_fail++;
      $display("FAIL counter_wrap: tc=%h bc=%h, want 0 0", bif.taken_count, bif.branch_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bif.stall = 1'b0;
    clear_ex();
    @(negedge clk);
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_back_to_back();
    test_stall();
    test_priority();
    test_offset_wrap();
    test_shadow_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Fetch-side consumer of the word-granular branch offset produced in EX. Owns the program counter: advances it by one per instruction (word addressing, no ×4), resolves beq/bne/j in EX, redirects fetch to the target, and kills the two wrong-path instructions already in flight. It sits between the EX stage and the IF stage, and drives flush controls into the ID/EX and EX/MEM pipeline registers.

## Interface
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard stall: hold PC (RUN state only).
- ex_valid  in  1  EX stage holds a real instruction.
- ex_beq  in  1  EX instruction is beq.
- ex_bne  in  1  EX instruction is bne.
- ex_jump  in  1  EX instruction is j.
- ex_pc_plus1  in  32  PC+1 of the EX instruction.
- ex_offset  in  32  sign-extended word offset (unshifted).
- ex_jindex  in  26  jump word index.
- ex_rs_data, ex_rt_data  in  32 each  compare operands (forwarded).
- pc  out  32  current fetch address.
- pc_plus1  out  32  pc+1, combinational.
- redirect  out  1  registered; high for the cycle in which pc holds a freshly loaded target.
- flush_id_ex  out  1  registered; load bubble into ID/EX at the next edge.
- flush_ex_mem  out  1  registered; load bubble into EX/MEM at the next edge.
- branch_count  out  CNT_W  resolved branches (beq/bne) in EX.
- taken_count  out  CNT_W  taken branches plus jumps.

## Operation
- States: RUN, SHADOW.
- take = ex_valid & state==RUN & (ex_jump | (ex_beq & rs==rt) | (ex_bne & rs!=rt)).
- Target: jump → {ex_pc_plus1[31:26], ex_jindex}; branch → ex_pc_plus1 + ex_offset, modulo 2^32 (wraps silently; negative offsets via two's complement).
- If several of ex_jump/ex_beq/ex_bne are set, ex_jump takes priority; beq/bne both set counts as beq.
- RUN:
  - take → pc <= target, state <= SHADOW; take has priority over stall.
  - else stall → pc held.
  - else → pc <= pc+1.
- SHADOW: lasts exactly one cycle, then state <= RUN.
  - ex_valid/ex_* ignored; no take possible.
  - stall ignored: pc <= pc+1.
- Wrong-path kill: at the taken edge, br+1 enters EX and br+2 enters ID. In SHADOW, flush_id_ex and flush_ex_mem are both 1, which kills both at the following edge. IF/ID is not flushed; it captures the target instruction.
- Counters:
  - branch_count increments on each edge where ex_valid & state==RUN & (ex_beq|ex_bne).
  - taken_count increments on each take.
  - Both wrap to 0 from all-ones.
- Reset (asynchronous, any time, including mid-SHADOW):
  - pc=RESET_PC, state=RUN.
  - redirect=0, flush_id_ex=0, flush_ex_mem=0.
  - counters=0.

## Timing
- Resolution is combinational in EX during cycle N. pc shows the target in cycle N+1, with redirect=flush_id_ex=flush_ex_mem=1 during N+1.
- Cycle N+2: pc=target+1, all flags 0, normal resolution resumes.
- Branch penalty: 2 cycles. Back-to-back taken branches are impossible; the second one is in the shadow.
- Not-taken branch: no penalty, pc increments as normal, flags stay 0.
- stall in RUN without take: pc frozen for every stalled cycle, resumes +1 on the first unstalled edge.
- pc_plus1 tracks pc within the same cycle; no added latency.

## Test plan
- Reset then 4 free-running cycles, no stall → pc 0,1,2,3; all flags 0; counters 0. Assert reset mid-count → pc returns to 0 asynchronously, before the next edge.
- beq taken: ex_pc_plus1=0x10, ex_offset=0xFFFFFFFC, rs=rt=5 → next cycle pc=0x0C with redirect/flush_id_ex/flush_ex_mem=1; the cycle after, pc=0x0D with flags 0; branch_count=1, taken_count=1.
- bne not taken: rs=rt=7, ex_pc_plus1=0x20, offset=8 → pc keeps incrementing; flags 0; branch_count=1, taken_count=0.
- Jump with pc_plus1=0xF0000004, jindex=0x0000123 → pc=0xF0000123. In the SHADOW cycle, hold ex_valid=1 with a taken beq → ignored; pc=0xF0000124 next; taken_count=1.
- stall=1 for 3 cycles at pc=7 → pc stays 7, then 8. stall=1 together with a taken branch (target 0x40) → pc=0x40. stall=1 during SHADOW → pc still advances to 0x41.
- Offset wrap: ex_pc_plus1=0xFFFFFFFF, offset=2, beq taken → pc=0x00000001. Preload taken_count to all-ones via 2^CNT_W takes (CNT_W=4 build) → wraps to 0.
